// File: rtl/layer_sequencer.sv
// layer_sequencer: drives a chain of NUM_LAYERS network layers one at a time.
// It pulses layer_start for the active layer and waits for that layer's
// finish pulse. A wrong finish, or a layer that runs TIMEOUT cycles,
// parks the block in a sticky error state that only abort clears.
//
// Ports
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   start        : one-cycle request to run one inference (IDLE only)
//   abort        : synchronous abort / error clear, highest priority
//   layer_finish : finish pulses from the layers, bit i = layer i
//   layer_start  : registered one-cycle start pulses, bit i = layer i
//   cur_layer    : index of the active layer
//   busy         : high while in START or WAIT
//   done         : registered one-cycle pulse when the inference completes
//   err          : sticky error flag
//   total_cycles : START+WAIT cycles of the last/current inference, saturating
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start
// S_START | layer_start[cur_layer] is high this cycle
// S_WAIT  | waiting for layer_finish[cur_layer], timeout counter runs
// S_DONE  | done is high this cycle, back to IDLE next
// S_ERROR | wrong finish or timeout seen, hold until abort
module layer_sequencer #(
  parameter int NUM_LAYERS = 7,
  parameter int TIMEOUT    = 1048575
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] layer_finish,
  output logic [NUM_LAYERS-1:0] layer_start,
  output logic [2:0]            cur_layer,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [23:0]           total_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [2:0]  LAST_LAYER = 3'(NUM_LAYERS - 1);
  // The counter holds the number of WAIT cycles already completed, so the
  // timeout fires on the TIMEOUT-th WAIT cycle.
  localparam logic [19:0] TO_LAST    = 20'(TIMEOUT - 1);
  localparam logic [23:0] TOTAL_MAX  = '1;

  state_t                  state_q, state_d;
  logic [2:0]              cur_layer_q, cur_layer_d;
  logic [19:0]             tcnt_q, tcnt_d;
  logic [23:0]             total_q, total_d;
  logic [NUM_LAYERS-1:0]   layer_start_q, layer_start_d;
  logic                    done_q, done_d;

  logic [NUM_LAYERS-1:0]   cur_onehot;
  logic                    finish_ok;
  logic                    finish_any;
  logic                    timeout_hit;

  assign cur_onehot  = NUM_LAYERS'(1) << cur_layer_q;
  assign finish_ok   = (layer_finish == cur_onehot);
  assign finish_any  = |layer_finish;
  assign timeout_hit = (tcnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    cur_layer_d = cur_layer_q;
    tcnt_d      = tcnt_q;
    total_d     = total_q;

    if ((state_q == S_START || state_q == S_WAIT) && total_q != TOTAL_MAX)
      total_d = total_q + 24'd1;

    unique case (state_q)
      S_IDLE: begin
        tcnt_d = '0;
        if (start) begin
          cur_layer_d = '0;
          total_d     = '0;
          state_d     = S_START;
        end
      end
      S_START: begin
        tcnt_d  = '0;
        state_d = finish_any ? S_ERROR : S_WAIT;
      end
      S_WAIT: begin
        tcnt_d = tcnt_q + 20'd1;
        // A valid finish wins over a timeout in the same cycle.
        if (finish_ok) begin
          if (cur_layer_q == LAST_LAYER) begin
            state_d = S_DONE;
          end else begin
            cur_layer_d = cur_layer_q + 3'd1;
            state_d     = S_START;
          end
        end else if (finish_any || timeout_hit) begin
          state_d = S_ERROR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      tcnt_d  = '0;
    end

    // Outputs are registered from the next state so they never follow
    // inputs combinationally.
    layer_start_d = (state_d == S_START) ? (NUM_LAYERS'(1) << cur_layer_d) : '0;
    done_d        = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cur_layer_q   <= '0;
      tcnt_q        <= '0;
      total_q       <= '0;
      layer_start_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_layer_q   <= cur_layer_d;
      tcnt_q        <= tcnt_d;
      total_q       <= total_d;
      layer_start_q <= layer_start_d;
      done_q        <= done_d;
    end
  end

  assign layer_start  = layer_start_q;
  assign done         = done_q;
  assign cur_layer    = cur_layer_q;
  assign busy         = (state_q == S_START) || (state_q == S_WAIT);
  assign err          = (state_q == S_ERROR);
  assign total_cycles = total_q;

endmodule
